// File: rtl/mux_arbiter_if.sv
// mux_arbiter_if: handshake bundle between the two router input buffers, the
// downstream output stage and the packet arbiter that steers the 2:1 output mux.
//   ivalid_0/1, itype_0/1 : flit valid and flit type from input buffers 0/1
//   oready                : downstream accepts the mux output this cycle
//   sel                   : one-hot mux select (01 port 0, 10 port 1, 0 none)
//   iready_0/1            : flit consumed from input buffer 0/1 this cycle
//   busy                  : a packet currently holds the grant
//   err                   : sticky protocol error flag
// Modports: master = traffic side (buffers + downstream), slave = arbiter.
interface mux_arbiter_if #(
    parameter int TYPEW = 2,
    parameter int SELW  = 5
);
    logic             ivalid_0;
    logic [TYPEW-1:0] itype_0;
    logic             ivalid_1;
    logic [TYPEW-1:0] itype_1;
    logic             oready;
    logic [SELW-1:0]  sel;
    logic             iready_0;
    logic             iready_1;
    logic             busy;
    logic             err;

    modport master (
        output ivalid_0, itype_0, ivalid_1, itype_1, oready,
        input  sel, iready_0, iready_1, busy, err
    );

    modport slave (
        input  ivalid_0, itype_0, ivalid_1, itype_1, oready,
        output sel, iready_0, iready_1, busy, err
    );
endinterface

// File: rtl/mux_arbiter.sv
// mux_arbiter: packet-level round-robin arbiter driving the select of the 2:1
// router output mux. A HEAD flit requests the grant; the grant is held until the
// owner's TAIL transfers (or MAXLEN flits have moved), then released. The losing
// port is backpressured through its iready.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active high
//   bus  : mux_arbiter_if.slave (flit valid/type in, oready in, sel/iready/busy/err out)
// Optional feature: define MUX_ARB_FASTSWITCH_EN to hand the grant straight to a
// waiting HEAD on the other port in the TAIL cycle, removing the idle bubble.

// Per-port flit decode: qualifies the type field with valid.
module mux_arb_port #(
    parameter int TYPEW = 2
) (
    input  logic             ivalid,
    input  logic [TYPEW-1:0] itype,
    output logic             vhead,
    output logic             vtail,
    output logic             vnone
);
    localparam logic [TYPEW-1:0] T_NONE = TYPEW'(0);
    localparam logic [TYPEW-1:0] T_HEAD = TYPEW'(1);
    localparam logic [TYPEW-1:0] T_TAIL = TYPEW'(2);

    assign vhead = ivalid & (itype == T_HEAD);
    assign vtail = ivalid & (itype == T_TAIL);
    assign vnone = ivalid & (itype == T_NONE);
endmodule

module mux_arbiter #(
    parameter int TYPEW  = 2,
    parameter int SELW   = 5,
    parameter int MAXLEN = 32,
    parameter int CNTW   = 6
) (
    input  logic         clk,
    input  logic         rst,
    mux_arbiter_if.slave bus
);
    localparam int NP = 2;
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(MAXLEN - 1);

    typedef enum logic {IDLE, LOCK} state_t;

    logic [NP-1:0]            ivalid_v;
    logic [NP-1:0][TYPEW-1:0] itype_v;
    logic [NP-1:0]            vhead, vtail, vnone;
    logic [NP-1:0]            iready_v;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            rr_q, rr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;

    logic winner;
    logic xfer_own;
    logic own_tail;
    logic forced;

    assign ivalid_v = {bus.ivalid_1, bus.ivalid_0};
    assign itype_v  = {bus.itype_1, bus.itype_0};

    for (genvar p = 0; p < NP; p++) begin : g_port
        mux_arb_port #(.TYPEW(TYPEW)) u_port (
            .ivalid (ivalid_v[p]),
            .itype  (itype_v[p]),
            .vhead  (vhead[p]),
            .vtail  (vtail[p]),
            .vnone  (vnone[p])
        );
    end

    function automatic logic [SELW-1:0] onehot(input logic p);
        logic [SELW-1:0] s;
        s    = '0;
        s[p] = 1'b1;
        return s;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        busy_d   = busy_q;
        err_d    = err_q;
        iready_v = '0;
        winner   = 1'b0;
        xfer_own = 1'b0;
        own_tail = 1'b0;
        forced   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // HEAD is only observed here; it is consumed as the first
                // flit once the grant is in place.
                if (|vhead) begin
                    winner  = (&vhead) ? rr_q : vhead[1];
                    state_d = LOCK;
                    owner_d = winner;
                    sel_d   = onehot(winner);
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
                if (|(ivalid_v & ~vhead))
                    err_d = 1'b1;
            end
            LOCK: begin
                // Only the owner sees oready; the other port is held upstream.
                iready_v[owner_q] = bus.oready;
                xfer_own = ivalid_v[owner_q] & bus.oready;
                own_tail = vtail[owner_q];
                forced   = xfer_own & ~own_tail & (cnt_q == LAST_CNT);
                if (xfer_own) begin
                    cnt_d = cnt_q + CNTW'(1);
                    // cnt_q==0 is the granting HEAD itself; any later HEAD is a
                    // missing TAIL and rides along as data.
                    if (vnone[owner_q] | (vhead[owner_q] & (cnt_q != '0)) | forced)
                        err_d = 1'b1;
                    if (own_tail | forced) begin
                        state_d = IDLE;
                        sel_d   = '0;
                        busy_d  = 1'b0;
                        rr_d    = ~owner_q;
`ifdef MUX_ARB_FASTSWITCH_EN
                        if (vhead[~owner_q]) begin
                            state_d = LOCK;
                            owner_d = ~owner_q;
                            sel_d   = onehot(~owner_q);
                            busy_d  = 1'b1;
                            cnt_d   = '0;
                            rr_d    = owner_q;
                        end
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sel      = sel_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;
    assign bus.iready_0 = iready_v[0];
    assign bus.iready_1 = iready_v[1];
endmodule

// File: tb/tb_mux_arbiter.sv
module tb_mux_arbiter;
    localparam int TYPEW  = 2;
    localparam int SELW   = 5;
    localparam int MAXLEN = 32;
    localparam int CNTW   = 6;

    localparam int T_HEAD = 1;
    localparam int T_TAIL = 2;
    localparam int T_DATA = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mux_arbiter_if #(.TYPEW(TYPEW), .SELW(SELW)) bus ();

    mux_arbiter #(.TYPEW(TYPEW), .SELW(SELW), .MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // flit type and tag queues per port, plus the expected transfer order
    int q0[$];
    int q1[$];
    int t0[$];
    int t1[$];
    int exp_q[$];
    int seq = 0;
    int xn0 = 0;
    int xn1 = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic drive();
        bus.ivalid_0 = (q0.size() != 0);
        bus.itype_0  = (q0.size() != 0) ? TYPEW'(q0[0]) : '0;
        bus.ivalid_1 = (q1.size() != 0);
        bus.itype_1  = (q1.size() != 0) ? TYPEW'(q1[0]) : '0;
    endtask

    task automatic sb_pop(input int p, input int tag);
        int e;
        if (exp_q.size() == 0) begin
            chk("sb_unexpected", p * 1000 + tag, 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            chk("sb_order", p * 1000 + tag, e);
        end
    endtask

    // One clock: observe transfers at negedge, advance sources after posedge.
    task automatic tick();
        logic a0, a1;
        int d;
        @(negedge clk);
        a0 = bus.ivalid_0 & bus.iready_0;
        a1 = bus.ivalid_1 & bus.iready_1;
        if (a0 === 1'b1) sb_pop(0, t0[0]);
        if (a1 === 1'b1) sb_pop(1, t1[0]);
        @(posedge clk);
        #1;
        if (a0 === 1'b1) begin d = q0.pop_front(); d = t0.pop_front(); xn0++; end
        if (a1 === 1'b1) begin d = q1.pop_front(); d = t1.pop_front(); xn1++; end
        drive();
        #1;
    endtask

    // HEAD, ndata DATA, optional TAIL; only the first nexp flits (all if <0)
    // are expected to transfer.
    task automatic enq(input int p, input int ndata, input bit tail, input int nexp);
        int total;
        int typ;
        total = ndata + 1 + (tail ? 1 : 0);
        for (int i = 0; i < total; i++) begin
            typ = (i == 0) ? T_HEAD : ((tail && i == total - 1) ? T_TAIL : T_DATA);
            if (p == 0) begin q0.push_back(typ); t0.push_back(seq); end
            else        begin q1.push_back(typ); t1.push_back(seq); end
            if (nexp < 0 || i < nexp) exp_q.push_back(p * 1000 + seq);
            seq++;
        end
        drive();
        #1;
    endtask

    task automatic clear_src();
        q0.delete(); q1.delete(); t0.delete(); t1.delete(); exp_q.delete();
        drive();
    endtask

    task automatic do_reset();
        clear_src();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_empty(input int p, input int budget, input string tag);
        int n;
        n = 0;
        while (((p == 0) ? q0.size() : q1.size()) != 0 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_drain"}, ((p == 0) ? q0.size() : q1.size()), 0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_sel"},  bus.sel, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_rdy0"}, bus.iready_0, 0);
        chk({tag, "_rdy1"}, bus.iready_1, 0);
        chk({tag, "_err"},  bus.err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        bus.oready = 1'b1;
        clear_src();

        // 1: reset and quiet bus
        repeat (2) begin tick(); chk_idle("t1_rst"); end
        rst = 1'b0;
        repeat (2) begin tick(); chk_idle("t1_quiet"); end

        // 2: port 1 packet, HEAD + 20 DATA + TAIL
        base = xn1;
        enq(1, 20, 1'b1, -1);
        chk("t2_sel_pre", bus.sel, 0);
        chk("t2_rdy_pre", bus.iready_1, 0);
        tick();
        chk("t2_sel_grant", bus.sel, 2);
        chk("t2_busy", bus.busy, 1);
        run_empty(1, 60, "t2");
        chk("t2_pulses", xn1 - base, 22);
        chk("t2_sel_rel", bus.sel, 0);
        chk("t2_busy_rel", bus.busy, 0);
        chk("t2_err", bus.err, 0);

        // rr now favours port 0: simultaneous HEADs go to port 0
        enq(0, 0, 1'b1, -1);
        enq(1, 0, 1'b1, -1);
        tick();
        chk("t2_rr_sel", bus.sel, 1);
        run_empty(0, 10, "t2_rr0");
        run_empty(1, 10, "t2_rr1");
        chk("t2_rr_sb", exp_q.size(), 0);

        // 3: both HEAD after reset
        do_reset();
        enq(0, 2, 1'b1, -1);
        enq(1, 2, 1'b1, -1);
        tick();
        chk("t3_sel0", bus.sel, 1);
        chk("t3_hold1", bus.iready_1, 0);
        run_empty(0, 20, "t3_p0");
`ifdef MUX_ARB_FASTSWITCH_EN
        chk("t3_fast_sel", bus.sel, 2);
        chk("t3_fast_busy", bus.busy, 1);
`else
        chk("t3_bubble_sel", bus.sel, 0);
        chk("t3_bubble_busy", bus.busy, 0);
        tick();
        chk("t3_sel1", bus.sel, 2);
`endif
        run_empty(1, 20, "t3_p1");
        chk("t3_sel_end", bus.sel, 0);
        chk("t3_sb", exp_q.size(), 0);
        chk("t3_err", bus.err, 0);

        // 4: port 0 packet with oready toggling every cycle
        base = xn0;
        enq(0, 20, 1'b1, -1);
        tick();
        chk("t4_sel", bus.sel, 1);
        n = 0;
        while (q0.size() != 0 && n < 100) begin
            bus.oready = ~bus.oready;
            #1;
            chk("t4_rdy_follow", bus.iready_0, bus.oready);
            chk("t4_busy", bus.busy, 1);
            tick();
            n++;
        end
        bus.oready = 1'b1;
        chk("t4_drain", q0.size(), 0);
        chk("t4_pulses", xn0 - base, 22);
        chk("t4_sel_end", bus.sel, 0);

        // 5: no TAIL, forced release after MAXLEN transfers
        do_reset();
        base = xn0;
        enq(0, 40, 1'b0, MAXLEN);
        tick();
        chk("t5_sel", bus.sel, 1);
        chk("t5_err_pre", bus.err, 0);
        n = 0;
        while ((xn0 - base) < MAXLEN && n < 100) begin tick(); n++; end
        chk("t5_count", xn0 - base, MAXLEN);
        chk("t5_sel_rel", bus.sel, 0);
        chk("t5_busy_rel", bus.busy, 0);
        chk("t5_err", bus.err, 1);
        repeat (3) tick();
        chk("t5_no_more", xn0 - base, MAXLEN);
        chk("t5_rdy", bus.iready_0, 0);
        chk("t5_err_sticky", bus.err, 1);

        // 6: reset mid-packet, then fresh packet
        do_reset();
        base = xn0;
        enq(0, 20, 1'b1, -1);
        tick();
        chk("t6_sel", bus.sel, 1);
        n = 0;
        while ((xn0 - base) < 10 && n < 40) begin tick(); n++; end
        chk("t6_count", xn0 - base, 10);
        rst = 1'b1;
        #1;
        chk("t6_sel_rst", bus.sel, 0);
        chk("t6_busy_rst", bus.busy, 0);
        chk("t6_rdy_rst", bus.iready_0, 0);
        clear_src();
        #1;
        rst = 1'b0;
        base = xn0;
        enq(0, 1, 1'b1, -1);
        tick();
        chk("t6_regrant", bus.sel, 1);
        run_empty(0, 10, "t6");
        chk("t6_pulses", xn0 - base, 3);
        chk("t6_sb", exp_q.size(), 0);
        chk("t6_err", bus.err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
